// File: rtl/up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl
//
// Modulo-programmable up counter with start/stop control, parallel load,
// wrap or one-shot mode and a registered terminal-count pulse. Used as a
// shared up-counting timebase for timers and sequencers.
//
// Ports:
//   clk      in   rising-edge system clock
//   rst      in   synchronous, active-low reset
//   start    in   clear count and enter RUN (restart if already running)
//   en       in   count enable while in RUN; low pauses the count
//   load     in   parallel load of din into q (state unchanged)
//   din      in   parallel load value
//   set_lim  in   capture lim_in into the limit register
//   lim_in   in   new terminal value
//   mode     in   0 = wrap at limit, 1 = one-shot (stop at limit)
//   q        out  current count (registered)
//   tc       out  one-cycle registered terminal-count pulse
//   busy     out  high while in RUN
//   done     out  high while in DONE (one-shot completed)
// ---------------------------------------------------------------------------
module up_counter_ctrl #(
    parameter int WIDTH       = 3,
    parameter int RESET_LIMIT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             set_lim,
    input  logic [WIDTH-1:0] lim_in,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(RESET_LIMIT);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] lim_q,   lim_d;
    logic             tc_q,    tc_d;

    // The limit register is updated independently of the count path, so a
    // set_lim in the same edge as load/start/count still takes effect; the
    // count decision below always uses the previously registered limit.
    always_comb begin
        lim_d = set_lim ? lim_in : lim_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;

        if (load) begin
            // load outranks start: the state is left untouched.
            cnt_d = din;
        end else if (start) begin
            cnt_d   = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && en) begin
            // >= rather than == so an over-limit loaded value is terminal
            // instead of running on to a silent overflow.
            if (cnt_q >= lim_q) begin
                tc_d = 1'b1;
                if (mode) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lim_q   <= LIM_RST;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            tc_q    <= tc_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_up_counter_ctrl.sv
module tb_up_counter_ctrl;

    localparam int W    = 3;
    localparam int RLIM = 7;

    logic         clk = 1'b0;
    logic         rst, start, en, load, set_lim, mode;
    logic [W-1:0] din, lim_in;
    logic [W-1:0] q;
    logic         tc, busy, done;

    int tests = 0;
    int fails = 0;

    up_counter_ctrl #(.WIDTH(W), .RESET_LIMIT(RLIM)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .load(load),
        .din(din), .set_lim(set_lim), .lim_in(lim_in), .mode(mode),
        .q(q), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst, start, en, load, set_lim, mode;
        logic [W-1:0] din, lim_in;
        logic [W-1:0] eq;
        logic         etc, ebusy, edone;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic s, input logic e,
                        input logic l, input logic [W-1:0] d,
                        input logic sl, input logic [W-1:0] li, input logic m,
                        input logic [W-1:0] eq, input logic et,
                        input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.en = e; v.load = l; v.din = d;
        v.set_lim = sl; v.lim_in = li; v.mode = m;
        v.eq = eq; v.etc = et; v.ebusy = eb; v.edone = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across one rising edge, then settle.
    task automatic step(input logic r, input logic s, input logic e,
                        input logic l, input logic [W-1:0] d,
                        input logic sl, input logic [W-1:0] li, input logic m);
        rst = r; start = s; en = e; load = l; din = d;
        set_lim = sl; lim_in = li; mode = m;
        @(posedge clk);
        #1;
    endtask

    // Reference model: count/limit as integers, activity as two flags.
    int  m_q, m_lim;
    bit  m_tc, m_run, m_fin;

    task automatic model_edge(input logic r, input logic s, input logic e,
                              input logic l, input int d,
                              input logic sl, input int li, input logic m);
        int nlim;
        if (!r) begin
            m_q = 0; m_tc = 0; m_run = 0; m_fin = 0; m_lim = RLIM;
        end else begin
            nlim = sl ? li : m_lim;
            m_tc = 0;
            if (l) begin
                m_q = d;
            end else if (s) begin
                m_q = 0; m_run = 1; m_fin = 0;
            end else if (m_run && e) begin
                if (m_q < m_lim) begin
                    m_q = m_q + 1;
                end else begin
                    m_tc = 1;
                    if (m) begin
                        m_run = 0; m_fin = 1;
                    end else begin
                        m_q = 0;
                    end
                end
            end
            m_lim = nlim;
        end
    endtask

    initial begin
        rst = 1'b0; start = 0; en = 0; load = 0; set_lim = 0; mode = 0;
        din = '0; lim_in = '0;

        //    rst st en ld din sl lim md | q tc busy done
        // Reset, and start ignored under reset
        addv(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        addv(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // Wrap mode, default limit 7
        addv(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        for (int i = 1; i <= 7; i++)
            addv(1, 0, 1, 0, 0, 0, 0, 0, W'(i), 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        for (int i = 1; i <= 5; i++)
            addv(1, 0, 1, 0, 0, 0, 0, 0, W'(i), 0, 1, 0);
        // Reset held two cycles mid-count at q=5
        addv(0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // Load 6 in RUN with limit back at 7
        addv(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        addv(1, 0, 1, 1, 6, 0, 0, 0,   6, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   7, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        // Pause and restart
        addv(1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   2, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   3, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   4, 0, 1, 0);
        addv(1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        // Load above limit 3 is terminal on the next enabled edge
        addv(1, 0, 0, 0, 0, 1, 3, 0,   0, 0, 1, 0);
        addv(1, 0, 0, 1, 5, 0, 0, 0,   5, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0);
        // Load beats start
        addv(1, 1, 0, 1, 2, 0, 0, 0,   2, 0, 1, 0);
        // One-shot with limit 4, set_lim alongside start
        addv(1, 1, 0, 0, 0, 1, 4, 1,   0, 0, 1, 0);
        for (int i = 1; i <= 4; i++)
            addv(1, 0, 1, 0, 0, 0, 0, 1, W'(i), 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0, 0, 1,   4, 1, 0, 1);
        addv(1, 0, 1, 0, 0, 0, 0, 1,   4, 0, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 1);
        addv(1, 1, 0, 1, 3, 0, 0, 0,   3, 0, 0, 1);
        addv(1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].en, vecs[i].load,
                 vecs[i].din, vecs[i].set_lim, vecs[i].lim_in, vecs[i].mode);
            check($sformatf("vec%0d.q", i),    int'(q),    int'(vecs[i].eq));
            check($sformatf("vec%0d.tc", i),   int'(tc),   int'(vecs[i].etc));
            check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].ebusy));
            check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].edone));
        end

        // limit = 0: wrap pulses tc every enabled edge, one-shot ends at once
        step(1, 0, 0, 0, 0, 1, 0, 0);
        check("lim0.setup_q", int'(q), 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0, 0, 0, 0);
            check($sformatf("lim0.wrap%0d", i), int'({q, tc, busy, done}), int'({3'd0, 1'b1, 1'b1, 1'b0}));
        end
        step(1, 0, 1, 0, 0, 0, 0, 1);
        check("lim0.oneshot", int'({q, tc, busy, done}), int'({3'd0, 1'b1, 1'b0, 1'b1}));
        step(1, 0, 1, 0, 0, 0, 0, 1);
        check("lim0.done_hold", int'({q, tc, busy, done}), int'({3'd0, 1'b0, 1'b0, 1'b1}));

        // Randomised run against the reference model
        step(0, 0, 0, 0, 0, 0, 0, 0);
        model_edge(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, s, e, l, sl, m;
            logic [W-1:0] d, li;
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 6);
            e  = ($urandom_range(0, 99) < 75);
            l  = ($urandom_range(0, 99) < 5);
            sl = ($urandom_range(0, 99) < 5);
            m  = ($urandom_range(0, 99) < 30);
            d  = W'($urandom);
            li = W'($urandom);
            step(r, s, e, l, d, sl, li, m);
            model_edge(r, s, e, l, int'(d), sl, int'(li), m);
            check($sformatf("rand%0d", i), int'({q, tc, busy, done}),
                  int'({W'(m_q), m_tc, m_run, m_fin}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/up_counter_ctrl.md
Name: up_counter_ctrl

Overview:
Parameterised, positive-edge-triggered, modulo-programmable up counter with start/stop control, parallel load, wrap or one-shot mode and a registered terminal-count pulse. It counts in the opposite direction to the existing 3-bit down counter. It is the shared up-counting timebase for timers and sequencers in the behavioural project. The default configuration is a 3-bit 0..7 counter driven by clk and rst.

Parameters:
WIDTH, 3, counter width in bits
RESET_LIMIT, 7, value loaded into the internal limit register at reset; must be <= 2^WIDTH-1

Ports:
clk     input   1      system clock; all state changes on rising edge
rst     input   1      synchronous, active-low reset; sampled on rising edge of clk
start   input   1      start/restart: clear count and enter RUN
en      input   1      count enable while in RUN; low = pause/hold
load    input   1      parallel load of din into q
din     input   WIDTH  parallel load value
set_lim input   1      capture lim_in into limit register
lim_in  input   WIDTH  new terminal value
mode    input   1      0 = wrap (free-running modulo limit+1), 1 = one-shot (stop at limit)
q       output  WIDTH  current count (registered)
tc      output  1      terminal-count pulse, one cycle, registered
busy    output  1      high while in RUN
done    output  1      high while in DONE (one-shot completed)

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low. When rst==0 at a rising edge:
  - q=0, tc=0, busy=0, done=0
  - state=IDLE, limit=RESET_LIMIT
  - All other inputs are ignored that cycle. Reset asserted mid-count aborts immediately; there is no partial completion.
- Priority at each edge, highest first: rst, load, start, counting. set_lim is independent and is applied in the same edge as any of these.
- Limit register: set_lim=1 sets limit<=lim_in. The new value takes effect from the next edge; comparisons use the registered limit.
- FSM states:
  - IDLE: q holds, busy=0, done=0. start -> RUN with q<=0.
  - RUN: busy=1. Sub-cases at each edge:
    - en=0: q holds, tc<=0, stay RUN.
    - en=1 and q<limit: q<=q+1, tc<=0.
    - en=1 and q>=limit, mode=0: q<=0, tc<=1, stay RUN.
    - en=1 and q>=limit, mode=1: q holds (not clamped), tc<=1, state->DONE.
    - start=1 in RUN: restart, q<=0, tc<=0.
  - DONE: done=1, busy=0, q holds, tc<=0 after its single pulse. start -> RUN with q<=0, done<=0.
- tc is high for exactly one cycle, in the cycle following the terminal edge. tc is 0 in IDLE and DONE except that single pulse.
- load=1 (any state except under reset):
  - q<=din, tc<=0, state unchanged.
  - load beats start in the same cycle: state is not changed by that start.
  - din>limit is accepted unclamped. The next enabled RUN edge treats it as terminal (>= compare).
- limit=0:
  - mode=0: q stays 0; tc pulses after every enabled edge.
  - mode=1: the first enabled edge goes to DONE.
- limit=2^WIDTH-1: full-range count. Wrap to 0 only via the terminal path; there is no implicit overflow path.
- mode is sampled at the terminal edge only. Changing mode mid-count is legal.
- Latency: start -> busy=1 and q=0 one cycle later. The first increment is on the next enabled edge.

Test Plan:
- Reset: hold rst=0 two cycles mid-count (q=5, RUN) -> after the edge q=0, busy=0, done=0, tc=0, limit=7. With rst=0 and start=1 together -> stays IDLE.
- Wrap mode, default limit 7, en=1 after start -> q: 0,1,...,7,0,1. tc=1 only in the cycle q returns to 0. busy stays 1.
- One-shot: set_lim lim_in=4, mode=1, start, en=1 -> q 0..4 then holds 4. tc one-cycle pulse, done=1, busy=0. A later start -> q=0, busy=1, done=0.
- Pause and restart: en toggles 1,0,0,1 from q=2 -> q 3,3,3,4. start at q=4 -> q=0, tc=0.
- Load: load din=6 in RUN with limit=7, en=1 -> q=6 then 7 then 0 with tc. load din=5 with limit=3 -> next enabled edge is terminal (mode 0: q=0, tc=1). load and start together -> q=din, state unchanged.
- limit=0: mode=0, en=1 -> q constant 0, tc high every cycle. mode=1 -> DONE after the first enabled edge.
